// File: rtl/eeprom_block_reader.sv
// Reads NUM_BYTES consecutive EEPROM locations through an external byte reader,
// retrying NACKed or timed-out attempts, and presents the block on data_out.
module eeprom_block_reader #(
    parameter int unsigned NUM_BYTES = 6,
    parameter int unsigned RETRIES   = 3,
    parameter int unsigned TIMEOUT   = 12500000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   dev_ext,
    input  logic [6:0]             dev_adr,
    input  logic [7:0]             base_adr,
    output logic                   busy,
    output logic                   done,
    output logic                   fail,
    output logic [8*NUM_BYTES-1:0] data_out,
    output logic [7:0]             retry_cnt,
    output logic                   rd_start,
    output logic                   rd_dev_ext,
    output logic [6:0]             rd_dev_adr,
    output logic [7:0]             rd_reg_adr,
    output logic                   rd_reset,
    input  logic                   rd_byte_rdy,
    input  logic [7:0]             rd_dat,
    input  logic                   rd_error
);

    typedef enum logic [2:0] {
        IDLE, GAP, ISSUE, WAIT, RECOVER, FINISH
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [3:0]             idx_q, idx_d;
    logic [7:0]             att_q, att_d, att_inc;
    logic                   err_q, err_d;
    logic [31:0]            wdog_q, wdog_d;
    logic [7:0]             base_q, base_d;
    logic [8*NUM_BYTES-1:0] shadow_q, shadow_d;
    logic [8*NUM_BYTES-1:0] data_d;
    logic                   fail_d;
    logic [7:0]             retry_d;
    logic                   ext_d;
    logic [6:0]             dev_d;
    logic                   bad_attempt;

    // Next-state and next-register computation; every output is a register fed from here.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        att_d       = att_q;
        err_d       = err_q;
        wdog_d      = wdog_q;
        base_d      = base_q;
        shadow_d    = shadow_q;
        data_d      = data_out;
        fail_d      = fail;
        retry_d     = retry_cnt;
        ext_d       = rd_dev_ext;
        dev_d       = rd_dev_adr;
        bad_attempt = 1'b0;
        att_inc     = att_q + 8'd1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    ext_d   = dev_ext;
                    dev_d   = dev_adr;
                    base_d  = base_adr;
                    idx_d   = '0;
                    att_d   = '0;
                    err_d   = 1'b0;
                    fail_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (cnt_q == 2'd3) begin
                    cnt_d   = '0;
                    state_d = ISSUE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ISSUE: begin
                wdog_d = '0;
                if (cnt_q == 2'd1) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            WAIT: begin
                if (rd_error) err_d = 1'b1;
                // A ready byte wins over a watchdog expiring in the same cycle.
                if (rd_byte_rdy) begin
                    if (!(err_q || rd_error)) begin
                        for (int unsigned i = 0; i < NUM_BYTES; i++) begin
                            if (32'(idx_q) == i) shadow_d[8*(NUM_BYTES-1-i) +: 8] = rd_dat;
                        end
                        if (32'(idx_q) == NUM_BYTES - 1) begin
                            data_d  = shadow_d;
                            fail_d  = 1'b0;
                            state_d = FINISH;
                        end else begin
                            idx_d   = idx_q + 4'd1;
                            att_d   = '0;
                            cnt_d   = '0;
                            state_d = GAP;
                        end
                    end else begin
                        bad_attempt = 1'b1;
                        cnt_d       = '0;
                        if (32'(att_inc) <= RETRIES) begin
                            state_d = GAP;
                        end else begin
                            fail_d  = 1'b1;
                            state_d = FINISH;
                        end
                    end
                end else if (wdog_q == 32'(TIMEOUT - 1)) begin
                    bad_attempt = 1'b1;
                    cnt_d       = '0;
                    state_d     = RECOVER;
                end else begin
                    wdog_d = wdog_q + 32'd1;
                end
            end
            RECOVER: begin
                // The attempt was already counted on expiry, so att_q is the number used.
                if (cnt_q == 2'd3) begin
                    cnt_d = '0;
                    if (32'(att_q) <= RETRIES) begin
                        state_d = GAP;
                    end else begin
                        fail_d  = 1'b1;
                        state_d = FINISH;
                    end
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (bad_attempt) begin
            err_d = 1'b0;
            att_d = att_inc;
            if (retry_cnt != 8'hFF) retry_d = retry_cnt + 8'd1;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            att_q      <= '0;
            err_q      <= 1'b0;
            wdog_q     <= '0;
            base_q     <= '0;
            shadow_q   <= '0;
            data_out   <= '0;
            fail       <= 1'b0;
            retry_cnt  <= '0;
            rd_dev_ext <= 1'b0;
            rd_dev_adr <= '0;
            rd_reg_adr <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rd_start   <= 1'b0;
            rd_reset   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            att_q      <= att_d;
            err_q      <= err_d;
            wdog_q     <= wdog_d;
            base_q     <= base_d;
            shadow_q   <= shadow_d;
            data_out   <= data_d;
            fail       <= fail_d;
            retry_cnt  <= retry_d;
            rd_dev_ext <= ext_d;
            rd_dev_adr <= dev_d;
            rd_reg_adr <= base_d + {4'h0, idx_d};
            busy       <= (state_d != IDLE);
            done       <= (state_d == FINISH);
            rd_start   <= (state_d == ISSUE);
            rd_reset   <= (state_d == RECOVER);
        end
    end

endmodule

// File: doc/eeprom_block_reader.md
EEPROM_BLOCK_READER -- requirements
Module: eeprom_block_reader

Interface
REQ-001 Parameter NUM_BYTES, default 6, number of consecutive EEPROM bytes read per request (1..16).
REQ-002 Parameter RETRIES, default 3, extra attempts allowed per byte after a failed attempt.
REQ-003 Parameter TIMEOUT, default 12500000, per-attempt watchdog in clk cycles (100 ms at 125 MHz).
REQ-004 One clock; reset is synchronous and active-high: clk  in  1  125-MHz clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 start  in  1  single-cycle request to read a block.
REQ-007 dev_ext  in  1  EEPROM uses two-byte addressing.
REQ-008 dev_adr  in  7  EEPROM I2C device address.
REQ-009 base_adr  in  8  first memory location to read.
REQ-010 busy  out  1  block read in progress.
REQ-011 done  out  1  one-cycle pulse at end of a request, success or failure.
REQ-012 fail  out  1  last request failed; level.
REQ-013 data_out  out  8*NUM_BYTES  assembled block, byte 0 in the most significant byte.
REQ-014 retry_cnt  out  8  saturating count of failed attempts since reset.
REQ-015 rd_start  out  1  byte-read request to the byte reader.
REQ-016 rd_dev_ext  out  1  latched dev_ext.
REQ-017 rd_dev_adr  out  7  latched dev_adr.
REQ-018 rd_reg_adr  out  8  current memory location.
REQ-019 rd_reset  out  1  reset to the byte reader for timeout recovery.
REQ-020 rd_byte_rdy  in  1  byte reader finished an attempt.
REQ-021 rd_dat  in  8  byte from the byte reader, valid while rd_byte_rdy is high.
REQ-022 rd_error  in  1  byte reader NACK pulse; arrives one cycle before rd_byte_rdy.

Function
REQ-023 States: IDLE, GAP, ISSUE, WAIT, RECOVER, FINISH.
REQ-024 IDLE: when start=1, latch dev_ext, dev_adr and base_adr; clear byte index, attempt count and error flag; clear fail; go to GAP; busy=1 from the next cycle until FINISH exits.
REQ-025 start while busy=1 is ignored.
REQ-026 GAP: wait 4 cycles, then go to ISSUE; this lets the byte reader return to its wait state.
REQ-027 ISSUE: drive rd_start=1 for exactly 2 cycles, clear the watchdog, then go to WAIT.
REQ-028 rd_reg_adr = base_adr + index, modulo 256 (0xFF wraps to 0x00).
REQ-029 WAIT: an rd_error pulse sets a sticky error flag for the current attempt.
REQ-030 WAIT, rd_byte_rdy=1 with error flag clear: write rd_dat into shadow byte [index]; on the last byte go to FINISH with success; otherwise increment index, reset the attempt count and go to GAP.
REQ-031 WAIT, rd_byte_rdy=1 with error flag set: failed attempt; increment retry_cnt (saturating at 255); clear the error flag; if attempts used <= RETRIES, go to GAP with the same index; else go to FINISH with failure.
REQ-032 WAIT: watchdog reaches TIMEOUT before rd_byte_rdy -> failed attempt; go to RECOVER.
REQ-033 RECOVER: rd_reset=1 for 4 cycles, then apply the retry/fail decision of REQ-031.
REQ-034 rd_byte_rdy and the watchdog expiring in the same cycle: rd_byte_rdy takes priority.
REQ-035 FINISH, success: copy the shadow register to data_out in one cycle; fail=0; done=1.
REQ-036 FINISH, failure: data_out keeps its previous value; fail=1; done=1.
REQ-037 FINISH always returns to IDLE on the next cycle.
REQ-038 rd_byte_rdy or rd_error outside WAIT is ignored.
REQ-039 All outputs are registered.

Reset
REQ-040 reset=1 forces IDLE and sets busy, done, fail, rd_start and rd_reset to 0.
REQ-041 reset=1 also clears data_out, retry_cnt, rd_reg_adr, rd_dev_adr and rd_dev_ext to 0.
REQ-042 reset in the middle of a request aborts it with no done pulse.

Verification
REQ-043 Clean read: base_adr=0xFA, NUM_BYTES=6, model returns 0x00,0x11,0x22,0x33,0x44,0x55 -> rd_reg_adr is 0xFA..0xFF in order; data_out=0x001122334455; one done pulse; fail=0; retry_cnt=0.
REQ-044 Wrap: base_adr=0xFE -> rd_reg_adr sequence is 0xFE,0xFF,0x00,0x01,0x02,0x03.
REQ-045 Single NACK: byte 2 has rd_error once -> byte 2 is re-read at the same address; success; retry_cnt=1.
REQ-046 Persistent NACK: byte 0 NACKs on 4 attempts -> done with fail=1; data_out unchanged; retry_cnt=4.
REQ-047 Timeout: the model never returns rd_byte_rdy and TIMEOUT is overridden to 1000 -> rd_reset pulses 4 cycles after every 1000-cycle wait; after 4 attempts, done with fail=1.
REQ-048 Abort and busy-start: reset asserted mid-byte-3 -> all outputs return to reset values with no done pulse; a start pulse while busy -> no second request is started.
